// File: rtl/adc_serial_responder.sv
// Serial ADC slave emulator: returns a latched parallel sample MSB-first on sdo, framed by cs_n/adclk.
// Latency 3 clk from pin edge to sdo/sdo_oe; the reader paces every bit, so there is no backpressure.
module adc_serial_responder #(
  parameter int DATA_W    = 16,
  parameter int LEAD_BITS = 2,
  parameter int FCNT_W    = 16
) (
  input  logic              clk,
  input  logic              sys_rst,
  input  logic              cs_n,
  input  logic              adclk,
  input  logic [DATA_W-1:0] sample_data,
  output logic              sdo,
  output logic              sdo_oe,
  output logic              frame_done,
  output logic              frame_abort,
  output logic [FCNT_W-1:0] frame_cnt
);

  localparam int SLOT_W = $clog2(LEAD_BITS + DATA_W + 1);
  localparam logic [SLOT_W-1:0] LEAD_END  = SLOT_W'(LEAD_BITS);
  localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(LEAD_BITS + DATA_W - 1);

  typedef enum logic [1:0] {IDLE, LEAD, DATA, TAIL} state_t;
  localparam state_t FIRST = (LEAD_BITS == 0) ? DATA : LEAD;

  logic cs_meta, cs_sync, cs_prev;
  logic sck_meta, sck_sync, sck_prev;
  logic cs_fall, cs_rise, sck_fall;

  state_t              state, state_n;
  logic [DATA_W-1:0]   shreg, shreg_n;
  logic [SLOT_W-1:0]   slot, slot_n;
  logic [FCNT_W-1:0]   cnt_n;
  logic                done_n, abort_n, sdo_n, oe_n;

  // Stages reset to 0 so a cs_n held low through reset never looks like a fall.
  always_ff @(posedge clk) begin
    if (sys_rst) begin
      cs_meta  <= 1'b0;
      cs_sync  <= 1'b0;
      cs_prev  <= 1'b0;
      sck_meta <= 1'b0;
      sck_sync <= 1'b0;
      sck_prev <= 1'b0;
    end else begin
      cs_meta  <= cs_n;
      cs_sync  <= cs_meta;
      cs_prev  <= cs_sync;
      sck_meta <= adclk;
      sck_sync <= sck_meta;
      sck_prev <= sck_sync;
    end
  end

  assign cs_fall  = cs_prev & ~cs_sync;
  assign cs_rise  = ~cs_prev & cs_sync;
  assign sck_fall = sck_prev & ~sck_sync;

  always_comb begin
    state_n = state;
    shreg_n = shreg;
    slot_n  = slot;
    cnt_n   = frame_cnt;
    done_n  = 1'b0;
    abort_n = 1'b0;
    unique case (state)
      IDLE: begin
        if (cs_fall) begin
          shreg_n = sample_data;
          slot_n  = '0;
          state_n = FIRST;
        end
      end
      LEAD: begin
        if (cs_rise) begin
          state_n = IDLE;
          abort_n = 1'b1;
        end else if (sck_fall) begin
          slot_n = slot + SLOT_W'(1);
          if (slot + SLOT_W'(1) == LEAD_END) state_n = DATA;
        end
      end
      DATA: begin
        // A coincident cs_rise takes priority over the final shift.
        if (cs_rise) begin
          state_n = IDLE;
          abort_n = 1'b1;
        end else if (sck_fall) begin
          shreg_n = {shreg[DATA_W-2:0], 1'b0};
          slot_n  = slot + SLOT_W'(1);
          if (slot == LAST_SLOT) begin
            state_n = TAIL;
            done_n  = 1'b1;
            cnt_n   = frame_cnt + FCNT_W'(1);
          end
        end
      end
      TAIL: begin
        if (cs_rise) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
    sdo_n = (state_n == DATA) ? shreg_n[DATA_W-1] : 1'b0;
    oe_n  = (state_n != IDLE);
  end

  always_ff @(posedge clk) begin
    if (sys_rst) begin
      state       <= IDLE;
      shreg       <= '0;
      slot        <= '0;
      sdo         <= 1'b0;
      sdo_oe      <= 1'b0;
      frame_done  <= 1'b0;
      frame_abort <= 1'b0;
      frame_cnt   <= '0;
    end else begin
      state       <= state_n;
      shreg       <= shreg_n;
      slot        <= slot_n;
      sdo         <= sdo_n;
      sdo_oe      <= oe_n;
      frame_done  <= done_n;
      frame_abort <= abort_n;
      frame_cnt   <= cnt_n;
    end
  end

endmodule

// File: tb/tb_adc_serial_responder.sv
// Directed bench for adc_serial_responder: models the reader at clk/8, scoreboards captured bits.
module tb_adc_serial_responder;
  localparam int DATA_W    = 16;
  localparam int LEAD_BITS = 2;
  localparam int FCNT_W    = 4;
  localparam int FRAME_LEN = LEAD_BITS + DATA_W;

  logic              clk = 1'b0;
  logic              sys_rst, cs_n, adclk;
  logic [DATA_W-1:0] sample_data;
  logic              sdo, sdo_oe, frame_done, frame_abort;
  logic [FCNT_W-1:0] frame_cnt;

  int vectors    = 0;
  int errors     = 0;
  int done_seen  = 0;
  int abort_seen = 0;
  int exp_cnt    = 0;
  bit exp_q[$];

  always #5 clk = ~clk;

  adc_serial_responder #(.DATA_W(DATA_W), .LEAD_BITS(LEAD_BITS), .FCNT_W(FCNT_W)) dut (
    .clk(clk), .sys_rst(sys_rst), .cs_n(cs_n), .adclk(adclk),
    .sample_data(sample_data), .sdo(sdo), .sdo_oe(sdo_oe),
    .frame_done(frame_done), .frame_abort(frame_abort), .frame_cnt(frame_cnt)
  );

  // Pulse-cycle counters: a pulse longer than 1 clk shows up as an extra count.
  always @(negedge clk) begin
    if (frame_done)  done_seen++;
    if (frame_abort) abort_seen++;
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One reader frame: nf falling edges; coincide drops cs_n with the last fall.
  task automatic frame(input logic [DATA_W-1:0] data, input logic [DATA_W-1:0] alt,
                       input int nf, input bit coincide);
    int d0, a0;
    bit full, e;
    d0   = done_seen;
    a0   = abort_seen;
    full = (nf >= FRAME_LEN) && !coincide;
    sample_data = data;
    cs_n = 1'b0;
    tick(4);
    sample_data = alt;
    tick(2);
    for (int i = 0; i < nf; i++) begin
      if (i < LEAD_BITS || i >= FRAME_LEN) e = 1'b0;
      else e = data[FRAME_LEN-1-i];
      exp_q.push_back(e);
      chk("sdo_oe_active", 32'(sdo_oe), 32'd1);
      adclk = 1'b1;
      chk("sdo_bit", 32'(sdo), 32'(exp_q.pop_front()));
      tick(4);
      if (coincide && i == nf - 1) cs_n = 1'b1;
      adclk = 1'b0;
      tick(4);
    end
    if (!coincide) begin
      tick(2);
      cs_n = 1'b1;
    end
    tick(3);
    chk("sdo_oe_release", 32'(sdo_oe), 32'd0);
    tick(3);
    if (full) exp_cnt = (exp_cnt + 1) % (1 << FCNT_W);
    chk("done_pulses", 32'(done_seen - d0), full ? 32'd1 : 32'd0);
    chk("abort_pulses", 32'(abort_seen - a0), full ? 32'd0 : 32'd1);
    chk("frame_cnt", 32'(frame_cnt), 32'(exp_cnt));
  endtask

  initial begin
    int d0, a0;
    sys_rst = 1'b1;
    cs_n = 1'b1;
    adclk = 1'b0;
    sample_data = '0;
    tick(3);
    chk("rst_sdo", 32'(sdo), 32'd0);
    chk("rst_sdo_oe", 32'(sdo_oe), 32'd0);
    chk("rst_done", 32'(frame_done), 32'd0);
    chk("rst_abort", 32'(frame_abort), 32'd0);
    chk("rst_cnt", 32'(frame_cnt), 32'd0);
    sys_rst = 1'b0;
    tick(5);
    chk("idle_oe", 32'(sdo_oe), 32'd0);

    frame(16'h0860, 16'h0860, FRAME_LEN, 1'b0);     // normal frame
    frame(16'h08B0, 16'h0C0C, FRAME_LEN, 1'b0);     // sample changes after latch
    frame(16'h0C0C, 16'h0C0C, FRAME_LEN, 1'b0);
    frame(16'hA5C3, 16'h0000, 9, 1'b0);             // abort mid-data
    frame(16'hFFFF, 16'hFFFF, FRAME_LEN + 2, 1'b0); // extra clocks in tail
    frame(16'h1234, 16'h1234, FRAME_LEN, 1'b1);     // coincident rise/last fall

    // Reset mid-DATA, with cs_n kept low through release.
    d0 = done_seen;
    a0 = abort_seen;
    sample_data = 16'hFFFF;
    cs_n = 1'b0;
    tick(6);
    for (int i = 0; i < 5; i++) begin
      adclk = 1'b1;
      tick(4);
      adclk = 1'b0;
      tick(4);
    end
    chk("pre_rst_sdo", 32'(sdo), 32'd1);
    sys_rst = 1'b1;
    tick(1);
    exp_cnt = 0;
    chk("midrst_sdo", 32'(sdo), 32'd0);
    chk("midrst_oe", 32'(sdo_oe), 32'd0);
    chk("midrst_cnt", 32'(frame_cnt), 32'd0);
    tick(2);
    sys_rst = 1'b0;
    tick(8);
    chk("held_low_oe", 32'(sdo_oe), 32'd0);
    for (int i = 0; i < 3; i++) begin
      adclk = 1'b1;
      tick(4);
      adclk = 1'b0;
      tick(4);
    end
    chk("held_low_oe2", 32'(sdo_oe), 32'd0);
    chk("held_low_sdo", 32'(sdo), 32'd0);
    chk("midrst_no_done", 32'(done_seen - d0), 32'd0);
    chk("midrst_no_abort", 32'(abort_seen - a0), 32'd0);
    cs_n = 1'b1;
    tick(6);
    frame(16'h5A5A, 16'h0001, FRAME_LEN, 1'b0);

    // Run complete frames until the counter wraps.
    for (int k = 0; k < (1 << FCNT_W) + 2 && (k == 0 || exp_cnt != 0); k++)
      frame(16'(k * 16'h1357 + 16'h0101), 16'h0000, FRAME_LEN, 1'b0);
    chk("wrap_cnt", 32'(frame_cnt), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
